game_state_sequencer: RTL and testbench

//  Game-logic engine that drives the game_state, wall_depth and collision

---
 rtl/game_state_sequencer.sv | 173 +++++++++++++++++
 tb/tb_game_state_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_state_sequencer.sv
// game_state_sequencer
//   Game-logic engine feeding the graphics compositor. Walks a wall toward the
//   players one depth unit every FRAMES_PER_STEP frames. Counts collision pixels
//   per frame and checks player depths whenever a wall clears. Reports
//   GAME_OVER / IN_PROGRESS / GAME_WIN / READY.
// Ports
//   clk_in              pixel clock
//   rst_n_in            asynchronous active-low reset
//   start_in            1-cycle start/restart pulse (ignored while in progress)
//   new_frame_in        1-cycle pulse at the first pixel of each frame
//   pixel_valid_in      pixel is inside the active area
//   is_collision_in     pixel is a collision pixel
//   player_depths_in    per-player depth, 4 x 8 bit
//   num_players_in      players 0..num_players_in-1 are checked; 0 = none
//   game_state_out      0 GAME_OVER, 1 IN_PROGRESS, 2 GAME_WIN, 3 READY
//   wall_depth_out      current wall depth
//   wall_index_out      walls cleared so far
//   collision_count_out collision pixels counted in the last completed frame
//
// state       | meaning
// S_OVER  (0) | game lost; all outputs held until start
// S_RUN   (1) | wall advancing, frames evaluated
// S_WIN   (2) | all walls cleared; outputs held until start
// S_READY (3) | post-reset idle, waiting for start
module game_state_sequencer #(
  parameter int MAX_WALL_DEPTH      = 75,
  parameter int GOAL_DEPTH          = 60,
  parameter int GOAL_DEPTH_DELTA    = 10,
  parameter int FRAMES_PER_STEP     = 4,
  parameter int COLLISION_THRESHOLD = 2000,
  parameter int NUM_WALLS           = 5
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        start_in,
  input  logic        new_frame_in,
  input  logic        pixel_valid_in,
  input  logic        is_collision_in,
  input  logic [7:0]  player_depths_in [3:0],
  input  logic [1:0]  num_players_in,
  output logic [2:0]  game_state_out,
  output logic [7:0]  wall_depth_out,
  output logic [2:0]  wall_index_out,
  output logic [15:0] collision_count_out
);

  typedef enum logic [2:0] {
    S_OVER  = 3'd0,
    S_RUN   = 3'd1,
    S_WIN   = 3'd2,
    S_READY = 3'd3
  } state_t;

  localparam logic [7:0]  DEPTH_MAX = 8'(MAX_WALL_DEPTH);
  localparam logic [7:0]  WIN_LO    = 8'(GOAL_DEPTH - GOAL_DEPTH_DELTA);
  localparam logic [7:0]  WIN_HI    = 8'(GOAL_DEPTH + GOAL_DEPTH_DELTA);
  localparam logic [15:0] DIV_LAST  = 16'(FRAMES_PER_STEP - 1);
  localparam logic [15:0] THRESH    = 16'(COLLISION_THRESHOLD);
  localparam logic [2:0]  LAST_WALL = 3'(NUM_WALLS - 1);
  localparam logic [2:0]  ALL_WALLS = 3'(NUM_WALLS);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_depth, w_depth_nxt;
  logic [2:0]  r_index, w_index_nxt;
  logic [15:0] r_count, w_count_nxt;
  logic [15:0] r_acc,   w_acc_nxt;
  logic [15:0] r_div,   w_div_nxt;

  logic w_hit, w_running, w_start_ok, w_in_window, w_over_thresh;
  logic w_step, w_clear, w_players_ok, w_crash;

  assign w_hit         = pixel_valid_in & is_collision_in;
  assign w_running     = (r_state == S_RUN);
  assign w_start_ok    = start_in & ~w_running;
  assign w_in_window   = (r_depth >= WIN_LO) && (r_depth <= WIN_HI);
  assign w_over_thresh = (r_acc >= THRESH);
  assign w_crash       = w_in_window & w_over_thresh;
  assign w_step        = (r_div == DIV_LAST);
  // <= 1 rather than == 1 so a depth of 0 can never be decremented
  assign w_clear       = (r_depth <= 8'd1);

  always_comb begin
    w_players_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if ((2'(i) < num_players_in) &&
          ((player_depths_in[i] < WIN_LO) || (player_depths_in[i] > WIN_HI)))
        w_players_ok = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= S_READY;
    else           r_state <= w_state_nxt;
  end

  // Next-state logic; a restart in a terminal state overrides frame evaluation
  always_comb begin
    w_state_nxt = r_state;
    if (w_start_ok) begin
      w_state_nxt = S_RUN;
    end else if (w_running && new_frame_in) begin
      if (w_crash)
        w_state_nxt = S_OVER;
      else if (w_step && w_clear)
        w_state_nxt = !w_players_ok        ? S_OVER :
                      (r_index == LAST_WALL) ? S_WIN  : S_RUN;
    end
  end

  // Output/datapath next values
  always_comb begin
    w_depth_nxt = r_depth;
    w_index_nxt = r_index;
    w_count_nxt = r_count;
    w_acc_nxt   = r_acc;
    w_div_nxt   = r_div;
    if (w_start_ok) begin
      w_depth_nxt = DEPTH_MAX;
      w_index_nxt = 3'd0;
      w_div_nxt   = 16'd0;
      w_acc_nxt   = 16'd0;
    end else if (w_running) begin
      if (new_frame_in) begin
        w_count_nxt = r_acc;
        // the pulse cycle itself is the first pixel of the new frame
        w_acc_nxt   = w_hit ? 16'd1 : 16'd0;
        if (!w_crash) begin
          if (w_step) begin
            w_div_nxt = 16'd0;
            if (!w_clear) begin
              w_depth_nxt = r_depth - 8'd1;
            end else if (w_players_ok) begin
              if (r_index == LAST_WALL) begin
                w_index_nxt = ALL_WALLS;
                w_depth_nxt = 8'd0;
              end else begin
                w_index_nxt = r_index + 3'd1;
                w_depth_nxt = DEPTH_MAX;
              end
            end
          end else begin
            w_div_nxt = r_div + 16'd1;
          end
        end
      end else if (w_hit && (r_acc != 16'hFFFF)) begin
        w_acc_nxt = r_acc + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_depth <= DEPTH_MAX;
      r_index <= 3'd0;
      r_count <= 16'd0;
      r_acc   <= 16'd0;
      r_div   <= 16'd0;
    end else begin
      r_depth <= w_depth_nxt;
      r_index <= w_index_nxt;
      r_count <= w_count_nxt;
      r_acc   <= w_acc_nxt;
      r_div   <= w_div_nxt;
    end
  end

  assign game_state_out      = r_state;
  assign wall_depth_out      = r_depth;
  assign wall_index_out      = r_index;
  assign collision_count_out = r_count;

endmodule

// File: tb/tb_game_state_sequencer.sv
module tb_game_state_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, new_frame, pix_valid, is_coll;
  logic [7:0]  pd [3:0];
  logic [1:0]  nplayers;
  logic [2:0]  st;
  logic [7:0]  depth;
  logic [2:0]  idx;
  logic [15:0] cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]  st;
    logic [7:0]  dep;
    logic [2:0]  idx;
    logic [15:0] cnt;
    bit          chk_cnt;
  } exp_t;

  exp_t  q[$];
  string nq[$];

  always #5 clk = ~clk;

  game_state_sequencer dut (
    .clk_in              (clk),
    .rst_n_in            (rst_n),
    .start_in            (start),
    .new_frame_in        (new_frame),
    .pixel_valid_in      (pix_valid),
    .is_collision_in     (is_coll),
    .player_depths_in    (pd),
    .num_players_in      (nplayers),
    .game_state_out      (st),
    .wall_depth_out      (depth),
    .wall_index_out      (idx),
    .collision_count_out (cnt)
  );

  // Monitor: compares every queued expectation at the falling edge
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e  = q.pop_front();
        nm = nq.pop_front();
        checks++;
        if (st !== e.st || depth !== e.dep || idx !== e.idx ||
            (e.chk_cnt && cnt !== e.cnt)) begin
          errors++;
          $display("FAIL %s: got st=%0d depth=%0d idx=%0d cnt=%0d, want st=%0d depth=%0d idx=%0d cnt=%0d%s",
                   nm, st, depth, idx, cnt, e.st, e.dep, e.idx, e.cnt,
                   e.chk_cnt ? "" : " (cnt not checked)");
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input logic [2:0] s, input logic [7:0] d,
                            input logic [2:0] i, input logic [15:0] c,
                            input bit chk, input string nm);
    exp_t e;
    e.st = s; e.dep = d; e.idx = i; e.cnt = c; e.chk_cnt = chk;
    q.push_back(e);
    nq.push_back(nm);
  endtask

  task automatic frame_pulse();
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
  endtask

  task automatic pixels(input int n);
    pix_valid = 1'b1;
    is_coll   = 1'b1;
    repeat (n) tick();
    pix_valid = 1'b0;
    is_coll   = 1'b0;
  endtask

  task automatic idle_frames(input int n);
    repeat (n) begin
      frame_pulse();
      tick();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; new_frame = 1'b0;
    pix_valid = 1'b0; is_coll = 1'b0; nplayers = 2'd0;
    pd[0] = 8'd60; pd[1] = 8'd60; pd[2] = 8'd60; pd[3] = 8'd60;
    repeat (3) tick();
    expect_now(3, 75, 0, 0, 1, "reset");
    rst_n = 1'b1;
    tick();
    idle_frames(2);
    expect_now(3, 75, 0, 0, 1, "ready_ignores_frames");

    pulse_start();
    expect_now(1, 75, 0, 0, 1, "start");

    for (int f = 1; f <= 8; f++) begin
      frame_pulse();
      expect_now(1, 8'(75 - f / 4), 0, 0, 1, $sformatf("frame%0d", f));
      tick();
    end

    idle_frames(8);
    expect_now(1, 71, 0, 0, 1, "reach71");
    pixels(5000);
    frame_pulse();
    expect_now(1, 71, 0, 5000, 1, "out_of_window_5000");
    tick();
    idle_frames(3);
    expect_now(1, 70, 0, 0, 1, "still_stepping");

    idle_frames(16);
    expect_now(1, 66, 0, 0, 1, "reach66");
    pixels(1999);
    frame_pulse();
    expect_now(1, 66, 0, 1999, 1, "thresh_minus1");
    tick();
    pulse_start();
    expect_now(1, 66, 0, 1999, 1, "start_ignored");
    idle_frames(3);
    expect_now(1, 65, 0, 0, 1, "reach65");
    pixels(2000);
    frame_pulse();
    expect_now(0, 65, 0, 2000, 1, "collision_over");
    tick();
    pixels(10);
    idle_frames(4);
    expect_now(0, 65, 0, 2000, 1, "over_hold");

    start = 1'b1; new_frame = 1'b1;
    tick();
    start = 1'b0; new_frame = 1'b0;
    expect_now(1, 75, 0, 0, 0, "restart_wins");
    tick();
    idle_frames(3);
    expect_now(1, 75, 0, 0, 1, "restart_frame_not_counted");
    idle_frames(1);
    expect_now(1, 74, 0, 0, 1, "first_step_after_restart");
    idle_frames(292);
    expect_now(1, 1, 0, 0, 1, "depth1");

    nplayers = 2'd2;
    pd[0] = 8'd60; pd[1] = 8'd55; pd[2] = 8'd200; pd[3] = 8'd0;
    idle_frames(4);
    expect_now(1, 75, 1, 0, 1, "wall_clear_60_55");
    pd[0] = 8'd50; pd[1] = 8'd70;
    idle_frames(300);
    expect_now(1, 75, 2, 0, 1, "wall_clear_edges");
    pd[0] = 8'd60; pd[1] = 8'd45;
    idle_frames(300);
    expect_now(0, 1, 2, 0, 1, "player_out_of_window");

    pulse_start();
    expect_now(1, 75, 0, 0, 1, "restart_after_over");
    nplayers = 2'd0;
    pd[0] = 8'd0; pd[1] = 8'd0;
    for (int w = 1; w <= 4; w++) begin
      idle_frames(300);
      expect_now(1, 75, 3'(w), 0, 1, $sformatf("wall%0d", w));
    end
    idle_frames(300);
    expect_now(2, 0, 5, 0, 1, "win");
    idle_frames(4);
    expect_now(2, 0, 5, 0, 1, "win_hold");
    pulse_start();
    expect_now(1, 75, 0, 0, 1, "restart_after_win");

    idle_frames(2);
    pixels(7);
    frame_pulse();
    expect_now(1, 75, 0, 7, 1, "count7");
    tick();
    pixels(10);
    rst_n = 1'b0;
    #1;
    expect_now(3, 75, 0, 0, 1, "reset_midframe");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    idle_frames(3);
    expect_now(1, 75, 0, 0, 1, "no_partial_state");
    idle_frames(1);
    expect_now(1, 74, 0, 0, 1, "divider_cleared");

    repeat (10) begin
      if (q.size() != 0) @(negedge clk);
    end
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations unchecked, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
